// File: rtl/display_pkg.sv
// Shared constants and helpers for the segment scan controller.
//   NUM_DIGITS     : number of time-multiplexed digits
//   SEG_TABLE      : hex digit to segment pattern, active-high, bits g..a
//   calc_scan_cnt  : dwell terminal count from clock and scan rates
//   sel_onehot     : active-high one-hot digit select from a digit index
package display_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int calc_scan_cnt(input int clock_freq, input int scan_freq);
        return clock_freq / scan_freq - 1;
    endfunction

    function automatic logic [7:0] sel_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side and display-side signals of the segment scan controller.
//   Disp_Data   : eight hex nibbles, [3:0] is digit 0
//   Disp_En     : per-digit enable
//   Disp_Dp     : per-digit decimal point
//   Data_Valid  : one-cycle capture strobe
//   Blank       : level, forces all segments off
//   SEG, SEL    : registered segment pattern and digit select
//   Frame_Start : one-cycle pulse when digit 0 begins its dwell
//   Pending     : captured data awaiting frame-boundary commit
// master = host/driver side, slave = controller side.
interface seg_scan_ctrl_if;

    logic [31:0] Disp_Data;
    logic [7:0]  Disp_En;
    logic [7:0]  Disp_Dp;
    logic        Data_Valid;
    logic        Blank;
    logic [7:0]  SEG;
    logic [7:0]  SEL;
    logic        Frame_Start;
    logic        Pending;

    modport master (
        output Disp_Data, Disp_En, Disp_Dp, Data_Valid, Blank,
        input  SEG, SEL, Frame_Start, Pending
    );

    modport slave (
        input  Disp_Data, Disp_En, Disp_Dp, Data_Valid, Blank,
        output SEG, SEL, Frame_Start, Pending
    );

endinterface

// File: rtl/hex7seg_decode.sv
// Combinational hex to 7-segment decoder with decimal point, blanking and
// output polarity.
//   nibble : hex digit
//   dp     : 1 lights the decimal point
//   blank  : 1 turns every segment (including dp) off
//   seg    : [0]=a .. [6]=g, [7]=dp; inverted when ACTIVE_LOW
module hex7seg_decode
    import display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] seg_ah;

    always_comb begin
        seg_ah = blank ? 8'h00 : {dp, SEG_TABLE[nibble]};
        seg    = ACTIVE_LOW ? ~seg_ah : seg_ah;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes eight hex digits onto SEG/SEL for the HC595 serial
// display driver. Host data lands in a pending buffer and is committed to the
// displayed (shadow) image only at the end of digit 7's dwell, so a frame is
// never torn.
//   Clk     : system clock
//   Reset_n : synchronous active-low reset
//   bus     : host inputs and registered display outputs (slave modport)
module seg_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLOCK_FREQ     = 50_000_000,
    parameter int SCAN_FREQ      = 1_000,
    parameter int SCAN_CNT       = calc_scan_cnt(CLOCK_FREQ, SCAN_FREQ),
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic           Clk,
    input  logic           Reset_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int              CNT_W   = $clog2(SCAN_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(SCAN_CNT);
    localparam logic [7:0]      SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0]      SEL_OFF = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [31:0]           pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [31:0]           shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [7:0]            seg_q, seg_d;
    logic [7:0]            sel_q, sel_d;
    logic                  wrap_q, wrap_d;
    logic                  frame_q, frame_d;

    logic                  tc;
    logic                  commit;
    logic [7:0]            dec_seg;

    hex7seg_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_decode (
        .nibble (shadow_data_q[{idx_q, 2'b00} +: 4]),
        .dp     (shadow_dp_q[idx_q]),
        .blank  (bus.Blank | ~shadow_en_q[idx_q]),
        .seg    (dec_seg)
    );

    always_comb begin
        tc     = (cnt_q == CNT_TC);
        commit = tc && (idx_q == 3'd7);

        cnt_d = tc ? '0 : cnt_q + 1'b1;
        idx_d = tc ? idx_q + 3'd1 : idx_q;

        pending_d     = pending_q;
        pend_data_d   = pend_data_q;
        pend_en_d     = pend_en_q;
        pend_dp_d     = pend_dp_q;
        shadow_data_d = shadow_data_q;
        shadow_en_d   = shadow_en_q;
        shadow_dp_d   = shadow_dp_q;

        if (commit) begin
            // A strobe landing on the commit cycle bypasses the pending buffer.
            if (bus.Data_Valid) begin
                shadow_data_d = bus.Disp_Data;
                shadow_en_d   = bus.Disp_En;
                shadow_dp_d   = bus.Disp_Dp;
            end else if (pending_q) begin
                shadow_data_d = pend_data_q;
                shadow_en_d   = pend_en_q;
                shadow_dp_d   = pend_dp_q;
            end
            pending_d = 1'b0;
        end else if (bus.Data_Valid) begin
            pend_data_d = bus.Disp_Data;
            pend_en_d   = bus.Disp_En;
            pend_dp_d   = bus.Disp_Dp;
            pending_d   = 1'b1;
        end

        seg_d = dec_seg;
        sel_d = sel_onehot(idx_q) ^ SEL_OFF;

        // Outputs trail idx by one cycle, so the frame pulse trails the wrap.
        wrap_d  = commit;
        frame_d = wrap_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            pend_data_q   <= '0;
            pend_en_q     <= '0;
            pend_dp_q     <= '0;
            shadow_data_q <= '0;
            shadow_en_q   <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_OFF;
            sel_q         <= SEL_OFF;
            wrap_q        <= 1'b0;
            frame_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            pend_data_q   <= pend_data_d;
            pend_en_q     <= pend_en_d;
            pend_dp_q     <= pend_dp_d;
            shadow_data_q <= shadow_data_d;
            shadow_en_q   <= shadow_en_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
            wrap_q        <= wrap_d;
            frame_q       <= frame_d;
        end
    end

    assign bus.SEG         = seg_q;
    assign bus.SEL         = sel_q;
    assign bus.Frame_Start = frame_q;
    assign bus.Pending     = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with CLOCK_FREQ=100, SCAN_FREQ=25
// (4-clock dwell, 32-clock frame). Each clock an expected SEG/SEL/
// Frame_Start/Pending record is pushed before the edge and popped after it.
// Expectations come from the cycle count k since reset release: the digit
// shown after edge k is (k/4)%8 and commits happen on edges with k%32==31.
module tb_seg_scan_ctrl;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] seg;
        logic       fs;
        logic       pend;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .CLOCK_FREQ     (100),
        .SCAN_FREQ      (25),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b0)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // Common-anode patterns for hex 0..F, dp off.
    logic [7:0] seg_lo [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          k     = 0;
    logic [31:0] m_data, p_data;
    logic [7:0]  m_en, m_dp, p_en, p_dp;
    logic        m_pend;

    task automatic step();
        exp_t e;
        exp_t x;
        int   d;
        if (!rst_n) begin
            e.sel  = 8'h00;
            e.seg  = 8'hFF;
            e.fs   = 1'b0;
            e.pend = 1'b0;
            k      = 0;
            m_data = '0; m_en = '0; m_dp = '0;
            p_data = '0; p_en = '0; p_dp = '0;
            m_pend = 1'b0;
        end else begin
            d     = (k / 4) % 8;
            e.sel = 8'h01 << d;
            if (bus.Blank || !m_en[d]) begin
                e.seg = 8'hFF;
            end else begin
                e.seg = seg_lo[m_data[d*4 +: 4]];
                if (m_dp[d]) e.seg = e.seg & 8'h7F;
            end
            e.fs = (k >= 32) && (k % 32 == 0);
            if (k % 32 == 31) begin
                if (bus.Data_Valid) begin
                    m_data = bus.Disp_Data; m_en = bus.Disp_En; m_dp = bus.Disp_Dp;
                end else if (m_pend) begin
                    m_data = p_data; m_en = p_en; m_dp = p_dp;
                end
                m_pend = 1'b0;
            end else if (bus.Data_Valid) begin
                p_data = bus.Disp_Data; p_en = bus.Disp_En; p_dp = bus.Disp_Dp;
                m_pend = 1'b1;
            end
            e.pend = m_pend;
            k++;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        total++;
        assert (bus.SEL === x.sel) else begin
            bad++;
            $error("FAIL sel k=%0d got=%h exp=%h", k, bus.SEL, x.sel);
        end
        total++;
        assert (bus.SEG === x.seg) else begin
            bad++;
            $error("FAIL seg k=%0d got=%h exp=%h", k, bus.SEG, x.seg);
        end
        total++;
        assert (bus.Frame_Start === x.fs) else begin
            bad++;
            $error("FAIL frame_start k=%0d got=%b exp=%b", k, bus.Frame_Start, x.fs);
        end
        total++;
        assert (bus.Pending === x.pend) else begin
            bad++;
            $error("FAIL pending k=%0d got=%b exp=%b", k, bus.Pending, x.pend);
        end
    endtask

    task automatic strobe(input logic [31:0] data, input logic [7:0] en, input logic [7:0] dp);
        bus.Disp_Data  = data;
        bus.Disp_En    = en;
        bus.Disp_Dp    = dp;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
    endtask

    initial begin
        bus.Disp_Data  = '0;
        bus.Disp_En    = '0;
        bus.Disp_Dp    = '0;
        bus.Data_Valid = 1'b0;
        bus.Blank      = 1'b0;
        rst_n          = 1'b0;

        // Reset, then blank walk with the first frame pulse at k=32.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (40) step();

        // Mid-frame strobe, committed at the next 7->0 wrap.
        strobe(32'h7654_3210, 8'hFF, 8'h00);
        repeat (70) step();

        // Upper hex digits with dp on digit 0.
        strobe(32'hFEDC_BA98, 8'hFF, 8'h01);
        repeat (70) step();

        // Only digits 0-3 enabled, then Blank for one dwell and for a full frame.
        strobe(32'h7654_3210, 8'h0F, 8'h00);
        repeat (40) step();
        for (int i = 0; i < 8 && (k % 4) != 0; i++) step();
        bus.Blank = 1'b1;
        repeat (4) step();
        bus.Blank = 1'b0;
        repeat (12) step();
        bus.Blank = 1'b1;
        repeat (34) step();
        bus.Blank = 1'b0;
        repeat (8) step();

        // Two strobes in one frame: last write wins.
        for (int i = 0; i < 32 && (k % 32) != 2; i++) step();
        strobe(32'h1111_1111, 8'hFF, 8'h00);
        repeat (5) step();
        strobe(32'h2222_2222, 8'hFF, 8'h00);
        repeat (70) step();

        // Strobe exactly on the commit cycle.
        for (int i = 0; i < 32 && (k % 32) != 31; i++) step();
        strobe(32'h0123_ABCD, 8'hFF, 8'hF0);
        repeat (40) step();

        // Reset mid-frame with data pending.
        for (int i = 0; i < 32 && (k % 32) != 10; i++) step();
        strobe(32'h89AB_CDEF, 8'hFF, 8'hFF);
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
